// File: rtl/lcd_pkg.sv
// lcd_pkg: shared LCD register definitions.
// PPU mode enum, offsets, reset values and STAT bit layout.
package lcd_pkg;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_ACTIVE = 2'd3
    } ppu_mode_t;

    localparam logic [3:0] OFF_LCDC = 4'h0;
    localparam logic [3:0] OFF_STAT = 4'h1;
    localparam logic [3:0] OFF_SCY  = 4'h2;
    localparam logic [3:0] OFF_SCX  = 4'h3;
    localparam logic [3:0] OFF_LY   = 4'h4;
    localparam logic [3:0] OFF_LYC  = 4'h5;
    localparam logic [3:0] OFF_DMA  = 4'h6;
    localparam logic [3:0] OFF_BGP  = 4'h7;
    localparam logic [3:0] OFF_OBP0 = 4'h8;
    localparam logic [3:0] OFF_OBP1 = 4'h9;
    localparam logic [3:0] OFF_WY   = 4'hA;
    localparam logic [3:0] OFF_WX   = 4'hB;

    localparam logic [7:0] RST_LCDC    = 8'h91;
    localparam logic [3:0] RST_STAT_EN = 4'h0;
    localparam logic [7:0] RST_SCY     = 8'h00;
    localparam logic [7:0] RST_SCX     = 8'h00;
    localparam logic [7:0] RST_LYC     = 8'h00;
    localparam logic [7:0] RST_BGP     = 8'hFC;
    localparam logic [7:0] RST_OBP0    = 8'hFF;
    localparam logic [7:0] RST_OBP1    = 8'hFF;
    localparam logic [7:0] RST_WY      = 8'h00;
    localparam logic [7:0] RST_WX      = 8'h00;
    localparam logic [7:0] RST_RDATA   = 8'h00;
    localparam logic [7:0] OPEN_BUS    = 8'hFF;

    localparam int LCDC_ON_BIT    = 7;
    localparam int STAT_EN_MSB    = 6;
    localparam int STAT_EN_LSB    = 3;
    localparam int STAT_COINC_BIT = 2;

    // Positions inside the 4-bit enable field
    localparam int EN_M0  = 0;
    localparam int EN_M1  = 1;
    localparam int EN_M2  = 2;
    localparam int EN_LYC = 3;

    function automatic logic [7:0] stat_pack(
        input logic [3:0] en,
        input logic       coinc,
        input logic [1:0] mode
    );
        return {1'b1, en, coinc, mode};
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// edge_pulse: one-cycle pulse on a rising level.
// hold_i tracks the level but suppresses the pulse.
module edge_pulse (
    input  logic cpu_clock,
    input  logic clr_i,
    input  logic hold_i,
    input  logic line_i,
    output logic pulse_o
);

    logic prev_q;
    logic pulse_q;
    logic pulse_d;

    assign pulse_d = line_i & ~prev_q & ~hold_i;

    // Remember the level and register the rising-edge pulse
    always_ff @(posedge cpu_clock) begin
        if (clr_i) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= line_i;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/lcd_regs.sv
// lcd_regs: LCD control/status registers at 0xFF40-0xFF4B.
// Define LCD_STAT_IRQ_EN to build the STAT interrupt logic.
module lcd_regs
    import lcd_pkg::*;
(
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       reg_sel,
    input  logic [3:0] reg_addr,
    input  logic       reg_wr,
    input  logic       reg_rd,
    input  logic [7:0] reg_wdata,
    output logic [7:0] reg_rdata,
    input  logic [1:0] ppu_mode,
    input  logic [7:0] ppu_ly,
    output logic [7:0] lcdc,
    output logic [7:0] scy,
    output logic [7:0] scx,
    output logic [7:0] bgp,
    output logic [7:0] obp0,
    output logic [7:0] obp1,
    output logic [7:0] wy,
    output logic [7:0] wx,
    output logic       lcd_on,
    output logic       irq_vblank,
    output logic       irq_stat
);

    logic [7:0] lcdc_q, scy_q, scx_q, lyc_q;
    logic [7:0] bgp_q, obp0_q, obp1_q, wy_q, wx_q;
    logic [3:0] stat_en_q;
    logic [7:0] rdata_q, rdata_d, rd_val;
    logic [7:0] ly_q, ly_d;
    logic       coinc_q, coinc_d;
    logic       fresh_q;
    logic       wr_hit, rd_hit;
    logic [1:0] mode_rd;
    logic       vblank_line;
    ppu_mode_t  mode;

    assign mode    = ppu_mode_t'(ppu_mode);
    assign wr_hit  = reg_sel & reg_wr;
    assign rd_hit  = reg_sel & reg_rd;
    assign lcd_on  = lcdc_q[LCDC_ON_BIT];
    assign mode_rd = lcd_on ? ppu_mode : 2'b00;

    // CPU writes to the writable registers
    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            lcdc_q    <= RST_LCDC;
            stat_en_q <= RST_STAT_EN;
            scy_q     <= RST_SCY;
            scx_q     <= RST_SCX;
            lyc_q     <= RST_LYC;
            bgp_q     <= RST_BGP;
            obp0_q    <= RST_OBP0;
            obp1_q    <= RST_OBP1;
            wy_q      <= RST_WY;
            wx_q      <= RST_WX;
        end else if (wr_hit) begin
            case (reg_addr)
                OFF_LCDC: lcdc_q    <= reg_wdata;
                OFF_STAT: stat_en_q <= reg_wdata[STAT_EN_MSB:STAT_EN_LSB];
                OFF_SCY:  scy_q     <= reg_wdata;
                OFF_SCX:  scx_q     <= reg_wdata;
                OFF_LYC:  lyc_q     <= reg_wdata;
                OFF_BGP:  bgp_q     <= reg_wdata;
                OFF_OBP0: obp0_q    <= reg_wdata;
                OFF_OBP1: obp1_q    <= reg_wdata;
                OFF_WY:   wy_q      <= reg_wdata;
                OFF_WX:   wx_q      <= reg_wdata;
                default:  ;
            endcase
        end
    end

    // Read mux; LY and mode read as zero while the LCD is off
    always_comb begin
        rd_val = OPEN_BUS;
        case (reg_addr)
            OFF_LCDC: rd_val = lcdc_q;
            OFF_STAT: rd_val = stat_pack(stat_en_q, coinc_q, mode_rd);
            OFF_SCY:  rd_val = scy_q;
            OFF_SCX:  rd_val = scx_q;
            OFF_LY:   rd_val = lcd_on ? ly_q : 8'h00;
            OFF_LYC:  rd_val = lyc_q;
            OFF_BGP:  rd_val = bgp_q;
            OFF_OBP0: rd_val = obp0_q;
            OFF_OBP1: rd_val = obp1_q;
            OFF_WY:   rd_val = wy_q;
            OFF_WX:   rd_val = wx_q;
            default:  rd_val = OPEN_BUS;
        endcase
    end

    assign rdata_d = rd_hit ? rd_val : rdata_q;
    assign ly_d    = lcd_on ? ppu_ly : 8'h00;
    assign coinc_d = lcd_on & (ly_q == lyc_q);

    // Read data, LY sample, coincidence flag and post-reset guard
    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            rdata_q <= RST_RDATA;
            ly_q    <= 8'h00;
            coinc_q <= 1'b0;
            fresh_q <= 1'b1;
        end else begin
            rdata_q <= rdata_d;
            ly_q    <= ly_d;
            coinc_q <= coinc_d;
            fresh_q <= 1'b0;
        end
    end

    assign vblank_line = lcd_on & (mode == MODE_VBLANK);

    edge_pulse u_vblank (
        .cpu_clock (cpu_clock),
        .clr_i     (reset),
        .hold_i    (fresh_q),
        .line_i    (vblank_line),
        .pulse_o   (irq_vblank)
    );

`ifdef LCD_STAT_IRQ_EN
    logic stat_line;

    assign stat_line = lcd_on & (
        (stat_en_q[EN_LYC] & coinc_q) |
        (stat_en_q[EN_M0] & (mode == MODE_HBLANK)) |
        (stat_en_q[EN_M1] & (mode == MODE_VBLANK)) |
        (stat_en_q[EN_M2] & (mode == MODE_OAM)));

    edge_pulse u_stat (
        .cpu_clock (cpu_clock),
        .clr_i     (reset),
        .hold_i    (fresh_q),
        .line_i    (stat_line),
        .pulse_o   (irq_stat)
    );
`else
    assign irq_stat = 1'b0;
`endif

    assign reg_rdata = rdata_q;
    assign lcdc      = lcdc_q;
    assign scy       = scy_q;
    assign scx       = scx_q;
    assign bgp       = bgp_q;
    assign obp0      = obp0_q;
    assign obp1      = obp1_q;
    assign wy        = wy_q;
    assign wx        = wx_q;

endmodule

// File: tb/tb_lcd_regs.sv
// tb_lcd_regs: table vectors, directed corner cases and a
// random run checked against a register-level reference model.
module tb_lcd_regs;

    logic       cpu_clock = 1'b0;
    logic       reset = 1'b1;
    logic       reg_sel = 1'b0;
    logic [3:0] reg_addr = 4'h0;
    logic       reg_wr = 1'b0;
    logic       reg_rd = 1'b0;
    logic [7:0] reg_wdata = 8'h00;
    logic [7:0] reg_rdata;
    logic [1:0] ppu_mode = 2'd0;
    logic [7:0] ppu_ly = 8'h00;
    logic [7:0] lcdc, scy, scx, bgp, obp0, obp1, wy, wx;
    logic       lcd_on, irq_vblank, irq_stat;

`ifdef LCD_STAT_IRQ_EN
    localparam bit STAT_IRQ = 1'b1;
`else
    localparam bit STAT_IRQ = 1'b0;
`endif

    lcd_regs dut (
        .cpu_clock  (cpu_clock),
        .reset      (reset),
        .reg_sel    (reg_sel),
        .reg_addr   (reg_addr),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .ppu_mode   (ppu_mode),
        .ppu_ly     (ppu_ly),
        .lcdc       (lcdc),
        .scy        (scy),
        .scx        (scx),
        .bgp        (bgp),
        .obp0       (obp0),
        .obp1       (obp1),
        .wy         (wy),
        .wx         (wx),
        .lcd_on     (lcd_on),
        .irq_vblank (irq_vblank),
        .irq_stat   (irq_stat)
    );

    always #5 cpu_clock = ~cpu_clock;

    int total = 0;
    int bad = 0;
    int n_vb = 0;
    int n_st = 0;

    // Reference model: plain byte array indexed by offset
    logic [7:0] m_r [16];
    logic [3:0] m_en;
    logic [7:0] m_ly, m_rdata;
    logic       m_coinc, m_vprev, m_sprev, m_fresh;
    logic       m_ivb, m_ist;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = 8'h00;
        m_r[0] = 8'h91;
        m_r[7] = 8'hFC;
        m_r[8] = 8'hFF;
        m_r[9] = 8'hFF;
        m_en = 4'h0;
        m_ly = 8'h00;
        m_rdata = 8'h00;
        m_coinc = 1'b0;
        m_vprev = 1'b0;
        m_sprev = 1'b0;
        m_ivb = 1'b0;
        m_ist = 1'b0;
        m_fresh = 1'b1;
    endtask

    task automatic model_step();
        logic on, vl, sl;
        logic [1:0] md;
        logic [7:0] rv;
        int a;
        if (reset) begin
            model_reset();
            return;
        end
        a = int'(reg_addr);
        on = m_r[0][7];
        md = on ? ppu_mode : 2'd0;
        if (a == 1) rv = {1'b1, m_en, m_coinc, md};
        else if (a == 4) rv = on ? m_ly : 8'h00;
        else if (a == 6 || a >= 12) rv = 8'hFF;
        else rv = m_r[a];
        vl = on && ppu_mode == 2'd1;
        sl = on && ((m_en[3] && m_coinc) ||
                    (m_en[0] && ppu_mode == 2'd0) ||
                    (m_en[1] && ppu_mode == 2'd1) ||
                    (m_en[2] && ppu_mode == 2'd2));
        m_ivb = vl && !m_vprev && !m_fresh;
        m_ist = STAT_IRQ && sl && !m_sprev && !m_fresh;
        m_vprev = vl;
        m_sprev = sl;
        m_fresh = 1'b0;
        m_coinc = on && (m_ly == m_r[5]);
        m_ly = on ? ppu_ly : 8'h00;
        if (reg_sel && reg_rd) m_rdata = rv;
        if (reg_sel && reg_wr) begin
            if (a == 1) m_en = reg_wdata[6:3];
            else if (!(a == 4 || a == 6 || a >= 12)) m_r[a] = reg_wdata;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge cpu_clock);
        #1;
        n_vb += int'(irq_vblank);
        n_st += int'(irq_stat);
        chk("rdata", reg_rdata, m_rdata);
        chk("irq_vblank", irq_vblank, m_ivb);
        chk("irq_stat", irq_stat, m_ist);
        chk("lcd_on", lcd_on, m_r[0][7]);
        chk("ppu_regs", {lcdc, scy, scx, bgp, obp0, obp1, wy, wx},
            {m_r[0], m_r[2], m_r[3], m_r[7],
             m_r[8], m_r[9], m_r[10], m_r[11]});
    endtask

    task automatic idle();
        reg_sel = 1'b0;
        reg_wr = 1'b0;
        reg_rd = 1'b0;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        reg_sel = 1'b1;
        reg_wr = 1'b1;
        reg_rd = 1'b0;
        reg_addr = a;
        reg_wdata = d;
        tick();
        idle();
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [7:0] v);
        reg_sel = 1'b1;
        reg_rd = 1'b1;
        reg_wr = 1'b0;
        reg_addr = a;
        tick();
        v = reg_rdata;
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] rexp [16];
        int c0, s0;

        rexp = '{8'h91, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFC,
                 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        // STAT first: coincidence (LY 0 == LYC 0) sets one edge later
        for (int i = 0; i < 16; i++) begin
            tbl[i].addr = (i == 0) ? 4'h1 : (i == 1) ? 4'h0 : 4'(i);
            tbl[i].exp = rexp[tbl[i].addr];
        end

        model_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset values, back-to-back reads
        reg_sel = 1'b1;
        reg_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            reg_addr = tbl[i].addr;
            tick();
            chk($sformatf("reset_rd_%0h", tbl[i].addr), reg_rdata, tbl[i].exp);
        end
        idle();

        // STAT write mask and read-only LY
        ppu_mode = 2'd2;
        ppu_ly = 8'h20;
        tick();
        tick();
        wr_reg(4'h1, 8'hFF);
        rd_reg(4'h1, v);
        chk("stat_mask", v, 8'hFA);
        wr_reg(4'h4, 8'h55);
        rd_reg(4'h4, v);
        chk("ly_ro", v, 8'h20);

        // Same-edge read and write returns old value
        reg_sel = 1'b1;
        reg_rd = 1'b1;
        reg_wr = 1'b1;
        reg_addr = 4'h3;
        reg_wdata = 8'hA5;
        tick();
        chk("rdwr_old", reg_rdata, 8'h00);
        idle();
        rd_reg(4'h3, v);
        chk("rdwr_new", v, 8'hA5);

        // VBLANK rise: one pulse, then none while held
        ppu_mode = 2'd0;
        do_reset();
        tick();
        tick();
        ppu_mode = 2'd1;
        tick();
        chk("vb_rise", irq_vblank, 1'b1);
        c0 = n_vb;
        for (int i = 0; i < 4560; i++) tick();
        chk("vb_hold", n_vb - c0, 0);

        // Reset mid-frame with VBLANK active: no pulse afterwards
        do_reset();
        tick();
        chk("rst_nopulse", irq_vblank, 1'b0);
        c0 = n_vb;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_quiet", n_vb - c0, 0);

        // LYC coincidence: pulse 3 cycles after ppu_ly change
        ppu_mode = 2'd3;
        ppu_ly = 8'h0F;
        do_reset();
        wr_reg(4'h5, 8'h10);
        wr_reg(4'h1, 8'h40);
        tick();
        tick();
        ppu_ly = 8'h10;
        tick();
        chk("lyc_c1", irq_stat, 1'b0);
        tick();
        chk("lyc_c2", irq_stat, 1'b0);
        tick();
        chk("lyc_c3", irq_stat, STAT_IRQ);
        rd_reg(4'h1, v);
        chk("lyc_coinc", v[2], 1'b1);

        // Mode 0 while the line is already high: no retrigger
        ppu_mode = 2'd2;
        wr_reg(4'h1, 8'h48);
        s0 = n_st;
        ppu_mode = 2'd0;
        for (int i = 0; i < 6; i++) tick();
        chk("stat_noretrig", n_st - s0, 0);

        // LCD off: LY and mode read 0, no pulses
        ppu_mode = 2'd3;
        wr_reg(4'h0, 8'h11);
        c0 = n_vb;
        s0 = n_st;
        ppu_mode = 2'd1;
        ppu_ly = 8'h50;
        tick();
        tick();
        rd_reg(4'h4, v);
        chk("off_ly", v, 8'h00);
        rd_reg(4'h1, v);
        chk("off_mode", v[1:0], 2'd0);
        chk("off_vb", n_vb - c0, 0);
        chk("off_st", n_st - s0, 0);

        // LCD on with VBLANK active: exactly one pulse
        wr_reg(4'h0, 8'h91);
        c0 = n_vb;
        tick();
        chk("on_vb_edge", irq_vblank, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("on_vb_once", n_vb - c0, 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            reg_sel = ($urandom_range(0, 7) != 0);
            reg_rd = $urandom_range(0, 1) == 1;
            reg_wr = $urandom_range(0, 2) == 0;
            reg_addr = 4'($urandom_range(0, 15));
            reg_wdata = 8'($urandom);
            if (reg_addr == 4'h0 && $urandom_range(0, 1) == 1)
                reg_wdata[7] = 1'b1;
            if ($urandom_range(0, 5) == 0)
                ppu_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                ppu_ly = 8'($urandom_range(0, 20));
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_regs.md
# lcd_regs

Memory-mapped LCD control/status register file (0xFF40–0xFF4B) between the CPU bus and the PPU. Holds LCDC, STAT, scroll, window and palette registers, exposes them to the PPU, and folds the PPU's mode and current line back into STAT/LY for CPU reads. Generates the VBLANK and STAT interrupt request pulses for the interrupt controller. Runs entirely in the cpu_clock domain, the same domain in which the PPU updates its mode.

## Interface
- No parameters; reset values come from the shared package.
- cpu_clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- reg_sel  in  1  address decoder hit for 0xFF40–0xFF4F
- reg_addr  in  4  register offset (CPU address bits 3:0)
- reg_wr  in  1  write strobe, one cycle per write
- reg_rd  in  1  read strobe, one cycle per read
- reg_wdata  in  8  write data
- reg_rdata  out  8  read data, registered
- ppu_mode  in  2  PPU mode: 0 HBLANK, 1 VBLANK, 2 OAM_SEARCH, 3 ACTIVE_PICTURE
- ppu_ly  in  8  line currently being produced by the PPU, 0–153
- lcdc, scy, scx, bgp, obp0, obp1, wy, wx  out  8 each  register contents to PPU
- lcd_on  out  1  LCDC bit 7
- irq_vblank  out  1  one-cycle VBLANK request pulse
- irq_stat  out  1  one-cycle STAT request pulse

## Operation
- Offsets: 0 LCDC, 1 STAT, 2 SCY, 3 SCX, 4 LY, 5 LYC, 6 DMA (not implemented), 7 BGP, 8 OBP0, 9 OBP1, A WY, B WX; C–F unmapped.
- Writes (reg_sel & reg_wr) take effect on that edge. STAT: only bits 6:3 (enables LYC, mode2, mode1, mode0) are writable. LY, offset 6 and unmapped offsets ignore writes.
- Reads (reg_sel & reg_rd) load reg_rdata on that edge. STAT reads {1, en[3:0], coinc, mode[1:0]}. LY reads ly_q. Offset 6 and unmapped offsets read 0xFF. reg_rdata holds its value when no read occurs.
- ly_q: ppu_ly registered every cycle. With lcd_on=0, ly_q is 0 and the STAT mode field reads 0.
- coinc: registered (ly_q == lyc); 0 while lcd_on=0.
- stat_line = lcd_on & ((en_lyc & coinc) | (en_m0 & mode==0) | (en_m1 & mode==1) | (en_m2 & mode==2)).
- irq_stat pulses when stat_line rises. While stat_line stays high, further conditions do not re-fire.
- irq_vblank pulses on the rising edge of (lcd_on & ppu_mode==1).
- Turning the LCD off drops both lines without pulsing. Turning it on while a condition is already true fires one pulse on the next edge.

## Timing
- Reset values: lcdc 0x91, STAT enables 0, scy/scx/lyc/wy/wx 0x00, bgp 0xFC, obp0/obp1 0xFF, reg_rdata 0x00, ly_q 0, coinc 0, irq pulses 0, edge-detector history 0.
- Write to read-back latency: a read one cycle after a write returns the new value.
- Read latency: reg_rdata is valid the cycle after reg_rd.
- ppu_ly → ly_q: 1 cycle. ly_q → coinc: 1 cycle. coinc → irq_stat: 1 cycle.
- ppu_mode change → irq_vblank or irq_stat: 1 cycle.
- A write to LYC on the same edge that ly_q changes: coinc compares against the new LYC from the following cycle.
- Simultaneous reg_rd and reg_wr to the same offset: read returns the old value.
- Reset asserted mid-frame: all state returns to reset values on that edge, and no pulse is generated on the following edge.

## Configuration
- LCD_STAT_IRQ_EN defined: STAT interrupt logic as above.
- LCD_STAT_IRQ_EN undefined: irq_stat is tied to 0 and stat_line/edge logic is removed. STAT enable bits still store and read back; coinc and mode remain readable.

## Structure
- lcd_pkg holds:
  - the ppu_mode_t enum (shared with the PPU)
  - register offset constants
  - reset-value constants
  - STAT bit-position constants
- Sub-module edge_pulse: rising-edge detector with a synchronous clear, instantiated for the VBLANK and STAT lines.

## Test plan
- Reset then read every offset -> 0x91, 0x80, 00, 00, 00, 00, FF, FC, FF, FF, 00, 00, and FF for C–F.
- Write 0xFF to STAT with ppu_mode=2 -> reads 0xFA. Write LY=0x55 -> LY read unchanged.
- ppu_mode steps 0→1 -> exactly one irq_vblank pulse, 1 cycle after the change. Mode held at 1 for 4560 cycles -> no further pulse.
- LYC=0x10, en_lyc=1, ppu_ly 0x0F→0x10 -> irq_stat pulses 3 cycles after the ppu_ly change, and STAT bit 2 reads 1.
- en_m0=1 and en_lyc=1, coincidence true, mode then goes to 0 while stat_line stays high -> no second irq_stat pulse.
- LCDC=0x11 (LCD off) with mode=1 -> LY reads 0, STAT mode reads 0, and no IRQ pulses. LCDC=0x91 with mode=1 -> one irq_vblank pulse.
